// File: rtl/aes_job_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_job_ctrl_if
//
// Purpose: groups the job-control signals of aes_job_ctrl into one bundle:
//   - controller side: trigger_i, len_i, soft_clear_i (inputs to the block)
//   - engine output stream observation: out_valid_i, out_ready_i
//   - engine control channel: eng_clear_o, eng_enable_o, eng_start_o,
//     eng_len_o
//   - status: busy_o, done_o, beats_o, err_o
//   - debug: state_o exposes the encoded FSM state
//
// Signal names keep the _i/_o suffixes as seen from aes_job_ctrl so the
// bundle lines up one-to-one with the block's documented port list.
//
// Modports:
//   slave  - used by aes_job_ctrl (drives the *_o signals)
//   master - used by the surrounding logic / testbench (drives the *_i
//            signals, observes the *_o signals)
//
// Handshake: out_valid_i/out_ready_i follow plain valid/ready semantics on
// the engine's output stream. A transfer (one 128-bit block, a "beat")
// happens in every clock cycle where both are high at the rising edge.
// This block only observes that stream; it never drives valid or ready.
// ---------------------------------------------------------------------------
interface aes_job_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             trigger_i;
    logic [CNT_W-1:0] len_i;
    logic             soft_clear_i;
    logic             out_valid_i;
    logic             out_ready_i;

    logic             eng_clear_o;
    logic             eng_enable_o;
    logic             eng_start_o;
    logic [CNT_W-1:0] eng_len_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] beats_o;
    logic             err_o;
    logic [2:0]       state_o;

    modport slave (
        input  trigger_i,
        input  len_i,
        input  soft_clear_i,
        input  out_valid_i,
        input  out_ready_i,
        output eng_clear_o,
        output eng_enable_o,
        output eng_start_o,
        output eng_len_o,
        output busy_o,
        output done_o,
        output beats_o,
        output err_o,
        output state_o
    );

    modport master (
        output trigger_i,
        output len_i,
        output soft_clear_i,
        output out_valid_i,
        output out_ready_i,
        input  eng_clear_o,
        input  eng_enable_o,
        input  eng_start_o,
        input  eng_len_o,
        input  busy_o,
        input  done_o,
        input  beats_o,
        input  err_o,
        input  state_o
    );
endinterface

// File: rtl/aes_job_ctrl.sv
// ---------------------------------------------------------------------------
// aes_job_ctrl
//
// Purpose: sequences the AES streaming engine through one job. On an
// accepted trigger the length is latched, the engine is cleared for one
// cycle, started for one cycle, then enabled until the requested number of
// 128-bit output blocks has been transferred on the engine output stream.
// Completion is signalled with a one-cycle done pulse. soft_clear aborts
// from any state and always clears the engine.
//
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous, active-high reset
//   bus     - aes_job_ctrl_if.slave bundle:
//               trigger_i, len_i, soft_clear_i  (controller requests)
//               out_valid_i, out_ready_i        (observed engine stream)
//               eng_clear_o, eng_enable_o, eng_start_o, eng_len_o
//               busy_o, done_o, beats_o, err_o  (status)
//               state_o                         (encoded FSM state)
//
// Parameters:
//   CNT_W       - width of the job length and the beat counter
//   WDOG_CYCLES - stall limit in cycles for the optional watchdog
//
// Configuration macro: AES_JOB_CTRL_WATCHDOG_EN
//   defined   - a stall counter runs in RUN; WDOG_CYCLES cycles without a
//               beat force ABORT and set the sticky err_o
//   undefined - no counter, err_o is constant 0, RUN waits indefinitely
//
// All outputs are decoded from registered state only (Moore), so there is
// no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module aes_job_ctrl #(
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    aes_job_ctrl_if.slave bus
);

    // Encoding is visible on state_o, keep it stable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ABORT = 3'd5
    } state_e;

    // A watchdog shorter than two cycles would fire on the first RUN cycle.
    if (WDOG_CYCLES < 2) begin : g_wdog_cycles_check
        $error("aes_job_ctrl: WDOG_CYCLES must be at least 2");
    end

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] beats_q;
    logic [CNT_W-1:0] beats_inc;
    logic             beat;
    logic             trig_accept;
    logic             last_beat;
    logic             wdog_fire;
    logic             err_q;

    // One completed output block on the engine stream.
    assign beat = bus.out_valid_i & bus.out_ready_i;

    // soft_clear outranks a trigger in IDLE: the trigger is dropped and
    // nothing gets latched.
    assign trig_accept = (state_q == ST_IDLE) & bus.trigger_i & ~bus.soft_clear_i;

    // Equality against the latched length; at saturation beats_inc wraps to
    // zero, which can never match a non-zero length.
    assign beats_inc = beats_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign last_beat = beat & (beats_inc == len_q);

`ifdef AES_JOB_CTRL_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q;

    // A beat in the limit cycle counts as progress, hence the ~beat term.
    assign wdog_fire = (state_q == ST_RUN) & ~beat & (wdog_q == WDOG_MAX);

    // Held at zero outside RUN, so it always starts from zero on RUN entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
        end else if ((state_q != ST_RUN) || beat) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky until the next accepted trigger. A simultaneous soft_clear
    // takes priority, so the abort is not reported as a watchdog error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (trig_accept) begin
            err_q <= 1'b0;
        end else if (wdog_fire && !bus.soft_clear_i) begin
            err_q <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign err_q     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // Priority: soft_clear > watchdog > normal transitions.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trig_accept) begin
                    // Zero-length jobs skip the engine entirely.
                    state_d = (bus.len_i != '0) ? ST_CLEAR : ST_DONE;
                end
            end
            ST_CLEAR: state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (wdog_fire) begin
            state_d = ST_ABORT;
        end

        // Applies in IDLE too, so the engine is always cleared on abort.
        if (bus.soft_clear_i) begin
            state_d = ST_ABORT;
        end
    end

    // ------------------------------------------------------------------
    // Job length and beat counter
    // Both hold after DONE/ABORT until the next accepted trigger.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q   <= '0;
            beats_q <= '0;
        end else if (trig_accept) begin
            len_q   <= bus.len_i;
            beats_q <= '0;
        end else if ((state_q == ST_RUN) && beat && (beats_q != {CNT_W{1'b1}})) begin
            beats_q <= beats_inc;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign bus.eng_clear_o  = (state_q == ST_CLEAR) | (state_q == ST_ABORT);
    assign bus.eng_enable_o = (state_q == ST_START) | (state_q == ST_RUN);
    assign bus.eng_start_o  = (state_q == ST_START);
    assign bus.eng_len_o    = len_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.done_o       = (state_q == ST_DONE);
    assign bus.beats_o      = beats_q;
    assign bus.err_o        = err_q;
    assign bus.state_o      = state_q;

endmodule

// File: tb/tb_aes_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_job_ctrl
//
// Directed testbench for aes_job_ctrl. Inputs change 1 ns after each rising
// edge; outputs are checked at that same point, i.e. they show the state
// registered at the edge just passed.
// ---------------------------------------------------------------------------
module tb_aes_job_ctrl;

    localparam int CNT_W = 16;
    localparam int WDOG  = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_job_ctrl_if #(.CNT_W(CNT_W)) bus ();

    aes_job_ctrl #(
        .CNT_W       (CNT_W),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic trig, input logic [CNT_W-1:0] len,
                         input logic sclr, input logic vld, input logic rdy);
        bus.trigger_i    = trig;
        bus.len_i        = len;
        bus.soft_clear_i = sclr;
        bus.out_valid_i  = vld;
        bus.out_ready_i  = rdy;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full snapshot of the control/status outputs.
    task automatic check_all(input string tag, input logic [2:0] st,
                             input logic clr, input logic en, input logic stt,
                             input logic [CNT_W-1:0] len, input logic busy,
                             input logic done, input logic [CNT_W-1:0] beats,
                             input logic err);
        check({tag, ".state"},  32'(bus.state_o),      32'(st));
        check({tag, ".clear"},  32'(bus.eng_clear_o),  32'(clr));
        check({tag, ".enable"}, 32'(bus.eng_enable_o), 32'(en));
        check({tag, ".start"},  32'(bus.eng_start_o),  32'(stt));
        check({tag, ".len"},    32'(bus.eng_len_o),    32'(len));
        check({tag, ".busy"},   32'(bus.busy_o),       32'(busy));
        check({tag, ".done"},   32'(bus.done_o),       32'(done));
        check({tag, ".beats"},  32'(bus.beats_o),      32'(beats));
        check({tag, ".err"},    32'(bus.err_o),        32'(err));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(0, '0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        check_all("reset", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---- basic job, len 3 ----
        drive(1, 3, 0, 0, 0);
        step();
        check_all("basic_clear", S_CLEAR, 1, 0, 0, 3, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        step();
        check_all("basic_start", S_START, 0, 1, 1, 3, 1, 0, 0, 0);
        step();
        check_all("basic_run", S_RUN, 0, 1, 0, 3, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 1);
        step();
        check("basic_beat1", 32'(bus.beats_o), 1);
        step();
        check("basic_beat2", 32'(bus.beats_o), 2);
        check("basic_nodone2", 32'(bus.done_o), 0);
        step();
        drive(0, 0, 0, 0, 0);
        check_all("basic_done", S_DONE, 0, 0, 0, 3, 1, 1, 3, 0);
        step();
        check_all("basic_idle", S_IDLE, 0, 0, 0, 3, 0, 0, 3, 0);

        // ---- back-pressure, len 2; re-trigger at earliest edge ----
        drive(1, 2, 0, 0, 0);
        step();
        check("bp_clear", 32'(bus.state_o), 32'(S_CLEAR));
        check("bp_beats_zeroed", 32'(bus.beats_o), 0);
        drive(0, 0, 0, 0, 0);
        step();
        step();
        check("bp_run", 32'(bus.state_o), 32'(S_RUN));
        drive(0, 0, 0, 1, 1);
        step();
        check("bp_beat1", 32'(bus.beats_o), 1);
        check("bp_busy1", 32'(bus.busy_o), 1);
        drive(0, 0, 0, 1, 0);
        step();
        check("bp_stall_beats", 32'(bus.beats_o), 1);
        check("bp_stall_busy", 32'(bus.busy_o), 1);
        check("bp_stall_nodone", 32'(bus.done_o), 0);
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check_all("bp_done", S_DONE, 0, 0, 0, 2, 1, 1, 2, 0);
        // Handshakes while idle must not count.
        drive(0, 0, 0, 1, 1);
        step();
        step();
        check_all("bp_idle_beats_ignored", S_IDLE, 0, 0, 0, 2, 0, 0, 2, 0);

        // ---- zero-length job ----
        drive(1, 0, 0, 0, 0);
        step();
        check_all("zero_done", S_DONE, 0, 0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        step();
        check_all("zero_idle", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---- abort after 2 beats, len 5; busy trigger ignored ----
        drive(1, 5, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        drive(1, 9, 0, 0, 0);
        step();
        check("abort_trig_ignored_state", 32'(bus.state_o), 32'(S_RUN));
        check("abort_trig_ignored_len", 32'(bus.eng_len_o), 5);
        drive(0, 0, 0, 1, 1);
        step();
        step();
        check("abort_beats2", 32'(bus.beats_o), 2);
        drive(1, 9, 1, 0, 0);
        step();
        check_all("abort_state", S_ABORT, 1, 0, 0, 5, 1, 0, 2, 0);
        drive(0, 0, 0, 0, 0);
        step();
        check_all("abort_idle", S_IDLE, 0, 0, 0, 5, 0, 0, 2, 0);

        // ---- soft_clear and trigger together in IDLE: abort wins ----
        drive(1, 4, 1, 0, 0);
        step();
        check_all("idle_sclr", S_ABORT, 1, 0, 0, 5, 1, 0, 2, 0);
        drive(0, 0, 0, 0, 0);
        step();
        check("idle_sclr_back", 32'(bus.state_o), 32'(S_IDLE));

        // ---- final beat coinciding with soft_clear: no done ----
        drive(1, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 1, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check("lastbeat_sclr_state", 32'(bus.state_o), 32'(S_ABORT));
        check("lastbeat_sclr_done", 32'(bus.done_o), 0);
        step();
        check("lastbeat_sclr_idle_done", 32'(bus.done_o), 0);
        check("lastbeat_sclr_idle", 32'(bus.state_o), 32'(S_IDLE));

        // ---- reset mid-RUN, then a len 1 job ----
        drive(1, 3, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 1, 1);
        step();
        check("rst_pre_beats", 32'(bus.beats_o), 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        check_all("rst_mid", S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check_all("rst_job_done", S_DONE, 0, 0, 0, 1, 1, 1, 1, 0);
        step();
        check("rst_job_idle", 32'(bus.state_o), 32'(S_IDLE));

`ifdef AES_JOB_CTRL_WATCHDOG_EN
        // ---- watchdog: len 4, one beat, then stall ----
        drive(1, 4, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check("wdog_beat1", 32'(bus.beats_o), 1);
        for (int i = 0; i < WDOG - 1; i++) begin
            step();
        end
        check("wdog_still_run", 32'(bus.state_o), 32'(S_RUN));
        check("wdog_no_err_yet", 32'(bus.err_o), 0);
        step();
        check_all("wdog_abort", S_ABORT, 1, 0, 0, 4, 1, 0, 1, 1);
        step();
        check_all("wdog_idle_sticky", S_IDLE, 0, 0, 0, 4, 0, 0, 1, 1);
        drive(1, 1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("wdog_err_cleared", 32'(bus.err_o), 0);
        check("wdog_retrig_state", 32'(bus.state_o), 32'(S_CLEAR));
        step();
        step();
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0);
        check("wdog_retrig_done", 32'(bus.done_o), 1);
        step();
`else
        // ---- no watchdog: RUN waits through a long stall ----
        drive(1, 2, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step();
        end
        check("nowdog_still_run", 32'(bus.state_o), 32'(S_RUN));
        check("nowdog_err", 32'(bus.err_o), 0);
        drive(0, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("nowdog_abort", 32'(bus.state_o), 32'(S_ABORT));
        check("nowdog_abort_err", 32'(bus.err_o), 0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_job_ctrl.md
# aes_job_ctrl

- Sequences the AES streaming engine through one job: clear, start, run until the requested number of 128-bit output blocks has left the engine, then signal completion.
- Sits between the register-file/controller slice (trigger, length, abort) and the engine's control channel (clear, enable, start, len).
- Tracks completed output beats by observing the engine's output stream handshake.

## Interface

Parameters
- `CNT_W`, default 16: width of the block-count length and of the beat counter.
- `WDOG_CYCLES`, default 1024: stall limit in cycles. Only used when the watchdog is compiled in.

Ports
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `trigger_i`  in  1  job start pulse. Honoured only in IDLE.
- `len_i`  in  CNT_W  number of 128-bit blocks in the job. Latched when a trigger is accepted.
- `soft_clear_i`  in  1  abort request. Honoured in any state.
- `out_valid_i`  in  1  engine output stream valid (observed only).
- `out_ready_i`  in  1  engine output stream ready (observed only).
- `eng_clear_o`  out  1  engine clear.
- `eng_enable_o`  out  1  engine enable.
- `eng_start_o`  out  1  engine start.
- `eng_len_o`  out  CNT_W  latched job length, driven to the engine.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `beats_o`  out  CNT_W  output blocks completed in the current or last job.
- `err_o`  out  1  sticky watchdog error.

## Operation

- Outputs are decoded from the registered state (Moore). No combinational path from any input to any output.
- States: IDLE, CLEAR, START, RUN, DONE, ABORT.
- **IDLE**
  - All engine controls are 0.
  - `trigger_i` with `len_i != 0`: latch `len_i`, zero `beats_o`, clear `err_o`, go to CLEAR.
  - `trigger_i` with `len_i == 0`: latch 0, zero `beats_o`, go to DONE. The engine is never enabled.
- **CLEAR**
  - `eng_clear_o = 1` for one cycle, then go to START.
- **START**
  - `eng_enable_o = 1` and `eng_start_o = 1` for one cycle, then go to RUN.
- **RUN**
  - `eng_enable_o = 1`.
  - A beat is a cycle where `out_valid_i & out_ready_i` is high. Each beat increments `beats_o`.
  - A beat that takes `beats_o` to the latched length sends the FSM to DONE.
- **DONE**
  - `done_o = 1` and `eng_enable_o = 0` for one cycle, then go to IDLE.
  - `beats_o` and `eng_len_o` hold their values until the next accepted trigger.
- **ABORT**
  - `eng_clear_o = 1` for one cycle, then go to IDLE. No `done_o`.
- Priority: `rst_i` > `soft_clear_i` > watchdog > normal transitions.
- `soft_clear_i` in IDLE also enters ABORT, so the engine is cleared.
- Beats seen outside RUN are ignored and `beats_o` does not change.
- `trigger_i` outside IDLE is ignored. It is not queued.
- `beats_o` saturates at `2^CNT_W-1`. Completion compares for equality, so saturation cannot be reached in a legal job.

## Timing

- Reset values:
  - State: IDLE.
  - Outputs: all 0. This includes `eng_len_o`, `beats_o` and `err_o`.
  - Watchdog counter: 0.
- Reset mid-job: the FSM returns to IDLE on the next edge. No `eng_clear_o` pulse is generated; the engine shares the same reset.
- Trigger accepted at edge N:
  - CLEAR during cycle N+1.
  - START during N+2.
  - RUN from N+3.
- Final beat at edge M: DONE (`done_o` high) during cycle M+1, IDLE from M+2.
  - The earliest re-trigger is accepted at edge M+2.
- Zero-length job triggered at edge N: `done_o` is high during N+1.
- `soft_clear_i` at edge K: ABORT during K+1, IDLE from K+2.
  - This applies even when it coincides with the final beat; `done_o` is suppressed.
- Trigger at the same edge as `soft_clear_i` in IDLE: the abort wins and the trigger is dropped.
- `eng_len_o` is stable from CLEAR through DONE.

## Configuration

- Macro: `AES_JOB_CTRL_WATCHDOG_EN`.
- **Defined**
  - A stall counter runs only in RUN.
  - It resets on every beat and on entry to RUN, and increments otherwise.
  - When it reaches `WDOG_CYCLES-1` without a beat, the next state is ABORT and `err_o` is set.
  - `err_o` stays set until the next accepted trigger or reset.
  - A beat in the same cycle as the limit counts as progress and prevents the abort.
- **Undefined**
  - No counter is instantiated, `err_o` is tied to 0, and RUN waits indefinitely.

## Test plan

- **Basic job:** reset, `len_i = 3`, trigger, then 3 beats with ready always high.
  - `eng_clear_o` pulses at +1 and `eng_start_o` at +2.
  - `done_o` pulses one cycle after the 3rd beat; `beats_o = 3`.
- **Back-pressure:** `len_i = 2`, `out_ready_i` toggling 1-0-1 while valid is held high.
  - Only handshake cycles count; `done_o` follows the 2nd handshake.
  - `busy_o` stays high throughout.
- **Zero length:** `len_i = 0`, trigger.
  - `done_o` is high the next cycle; `eng_enable_o`, `eng_clear_o` and `eng_start_o` never assert.
- **Abort:** `len_i = 5`, `soft_clear_i` after 2 beats.
  - One-cycle `eng_clear_o`, then IDLE; no `done_o`; `beats_o = 2`.
  - A trigger issued while busy is ignored.
- **Reset mid-RUN:** assert `rst_i` for 1 cycle during RUN.
  - All outputs read 0 and the FSM is in IDLE; a new `len_i = 1` job completes normally.
- **Watchdog** (macro defined, `WDOG_CYCLES = 8`): `len_i = 4`, 1 beat, then no valid.
  - ABORT entered 8 cycles after the beat; `err_o = 1`.
  - The next trigger clears `err_o`.
